// File: rtl/mcmult_issue_ctrl.sv
// Issue sequencer for the multi-cycle 5x5-slice multiplier: holds one op in flight,
// drives start/mode/a/b for 1/2/4 cycles, captures and sign-extends the result.
module mcmult_issue_ctrl #(
  parameter int N     = 8,
  parameter int M     = 8,
  parameter int OUT_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [N-1:0]     req_a,
  input  logic [M-1:0]     req_b,
  output logic             mul_start,
  output logic [1:0]       mul_mode,
  output logic [N-1:0]     mul_a,
  output logic [M-1:0]     mul_b,
  input  logic [OUT_W-1:0] mul_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic [1:0]       rsp_mode,
  output logic             busy
);
  localparam int SW = $clog2(OUT_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]      cnt;
  logic [1:0]      last;
  logic            accept;
  logic            fin;
  logic [SW-1:0]   sh;
  logic [OUT_W-1:0] shl;
  logic [OUT_W-1:0] sext;

  assign last      = (mul_mode == 2'b00) ? 2'd0 : (mul_mode == 2'b01) ? 2'd1 : 2'd3;
  assign req_ready = (state == IDLE) | ((state == DONE) & rsp_ready);
  assign accept    = req_valid & req_ready;
  assign fin       = (state == RUN) && (cnt == last);
  assign mul_start = (state == RUN) && (cnt == 2'd0);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Left-justify the product's sign bit, then arithmetic-shift back down.
  assign sh   = (mul_mode == 2'b00) ? SW'(OUT_W-10) :
                (mul_mode == 2'b01) ? SW'(OUT_W-12) : SW'(OUT_W-16);
  assign shl  = mul_out << sh;
  assign sext = OUT_W'($signed(shl) >>> sh);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = RUN;
      RUN:     if (fin) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = req_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      mul_mode <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      rsp_data <= '0;
      rsp_mode <= '0;
    end else begin
      if (accept) begin
        mul_mode <= req_mode;
        mul_a    <= req_a;
        mul_b    <= req_b;
        cnt      <= '0;
      end else if ((state == RUN) && !fin) begin
        cnt <= cnt + 2'd1;
      end
      if (fin) begin
        rsp_data <= sext;
        rsp_mode <= mul_mode;
      end
    end
  end
endmodule

// File: tb/tb_mcmult_issue_ctrl.sv
// Directed bench for mcmult_issue_ctrl with a behavioural multiplier that only
// presents a valid product on the final cycle of each op.
module tb_mcmult_issue_ctrl;
  logic        clk = 0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_mode;
  logic [7:0]  req_a, req_b;
  logic        mul_start;
  logic [1:0]  mul_mode;
  logic [7:0]  mul_a, mul_b;
  logic [17:0] mul_out;
  logic        rsp_valid, rsp_ready;
  logic [17:0] rsp_data;
  logic [1:0]  rsp_mode;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  mcmult_issue_ctrl #(.N(8), .M(8), .OUT_W(18)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b),
    .mul_start(mul_start), .mul_mode(mul_mode), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_mode(rsp_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: product truncated to slice width, upper bits zero, junk off-cycle.
  logic [2:0]         mcnt = 0;
  logic [2:0]         idx, lm1;
  logic signed [15:0] p;
  always @(posedge clk) mcnt <= mul_start ? 3'd1 : (mcnt == 3'd7 ? mcnt : mcnt + 3'd1);
  always_comb begin
    idx = mul_start ? 3'd0 : mcnt;
    lm1 = (mul_mode == 2'b00) ? 3'd0 : (mul_mode == 2'b01) ? 3'd1 : 3'd3;
    p   = '0;
    case (mul_mode)
      2'b00:   p = $signed(mul_a[4:0]) * $signed(mul_b[4:0]);
      2'b01:   p = $signed(mul_a[4:0]) * $signed(mul_b);
      default: p = $signed(mul_a) * $signed(mul_b);
    endcase
    mul_out = 18'h2AAAA;
    if (idx == lm1) begin
      case (mul_mode)
        2'b00:   mul_out = {8'b0, p[9:0]};
        2'b01:   mul_out = {6'b0, p[11:0]};
        default: mul_out = {2'b0, p[15:0]};
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic look;
    #2;
  endtask

  task automatic run_op(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b,
                        input int len, input logic [17:0] exp_d);
    req_valid = 1; req_mode = mode; req_a = a; req_b = b;
    look; chk("acc_ready", req_ready, 1);
    cyc; req_valid = 0;
    for (int i = 0; i < len; i++) begin
      look;
      chk("run_start", mul_start, (i == 0));
      chk("run_mode", mul_mode, mode);
      chk("run_a", mul_a, a);
      chk("run_b", mul_b, b);
      chk("run_rsp_valid", rsp_valid, 0);
      cyc;
    end
    look;
    chk("done_valid", rsp_valid, 1);
    chk("done_data", rsp_data, exp_d);
    chk("done_mode", rsp_mode, mode);
    cyc; look;
    chk("retired", rsp_valid, 0);
  endtask

  logic [7:0]  sa [3];
  logic [7:0]  sb [3];
  logic [17:0] se [3];

  initial begin
    sa = '{8'h01, 8'h1F, 8'h0F};
    sb = '{8'h05, 8'h7F, 8'h80};
    se = '{18'h00005, 18'h3FF81, 18'h3F880};
    rst = 1; req_valid = 0; req_mode = 0; req_a = 0; req_b = 0; rsp_ready = 0;
    cyc; cyc; look;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_mul_a", mul_a, 0);
    rst = 0;
    cyc; look;
    chk("idle_ready", req_ready, 1);

    // Basic modes
    rsp_ready = 1;
    run_op(2'b00, 8'h1F, 8'h03, 1, 18'h3FFFD);
    run_op(2'b01, 8'h1D, 8'd100, 2, 18'h3FED4);
    run_op(2'b10, 8'h80, 8'h80, 4, 18'h04000);
    run_op(2'b11, 8'h80, 8'h80, 4, 18'h04000);

    // Backpressure, then retire+accept in the same cycle
    rsp_ready = 0;
    req_valid = 1; req_mode = 2'b00; req_a = 8'h02; req_b = 8'h03;
    look; cyc; req_valid = 0;
    look; chk("bp_start", mul_start, 1);
    cyc;
    req_valid = 1; req_mode = 2'b01; req_a = 8'h1D; req_b = 8'd100;
    for (int i = 0; i < 5; i++) begin
      look;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 18'h00006);
      chk("bp_ready", req_ready, 0);
      cyc;
    end
    rsp_ready = 1;
    look; chk("bp_accept", req_ready, 1);
    cyc; req_valid = 0;
    look;
    chk("bp_next_start", mul_start, 1);
    chk("bp_next_rsp", rsp_valid, 0);
    chk("bp_next_mode", mul_mode, 2'b01);
    cyc; look; chk("bp_run_rsp", rsp_valid, 0);
    cyc; look;
    chk("bp_next_valid", rsp_valid, 1);
    chk("bp_next_data", rsp_data, 18'h3FED4);
    cyc; look; chk("bp_idle", busy, 0);

    // Stream of three mode-01 ops
    req_valid = 1; req_mode = 2'b01; req_a = sa[0]; req_b = sb[0];
    for (int k = 0; k < 3; k++) begin
      look;
      chk("st_accept", req_ready, 1);
      if (k > 0) begin
        chk("st_valid", rsp_valid, 1);
        chk("st_data", rsp_data, se[k-1]);
      end
      cyc;
      req_valid = (k < 2);
      if (k < 2) begin req_a = sa[k+1]; req_b = sb[k+1]; end
      look;
      chk("st_start", mul_start, 1);
      chk("st_a", mul_a, sa[k]);
      chk("st_ready_run", req_ready, 0);
      cyc; look;
      chk("st_start2", mul_start, 0);
      chk("st_a2", mul_a, sa[k]);
      cyc;
    end
    look;
    chk("st_valid_last", rsp_valid, 1);
    chk("st_data_last", rsp_data, se[2]);
    cyc; look; chk("st_idle", busy, 0);

    // Reset in the middle of a mode-10 op
    req_valid = 1; req_mode = 2'b10; req_a = 8'h11; req_b = 8'h22;
    look; cyc; req_valid = 0;
    look; chk("mr_start", mul_start, 1);
    cyc; rst = 1;
    look; chk("mr_busy_pre", busy, 1);
    cyc; rst = 0;
    look;
    chk("mr_busy", busy, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_start0", mul_start, 0);
    chk("mr_mul_a", mul_a, 0);
    chk("mr_rsp_data", rsp_data, 0);
    for (int i = 0; i < 5; i++) begin
      cyc; look; chk("mr_no_rsp", rsp_valid, 0);
    end
    run_op(2'b00, 8'h03, 8'h05, 1, 18'h0000F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
